// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// M-extension func3 codes, FSM states and operand-signedness helpers.
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the core controller (master) and the MDU (slave).
interface mdu_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, rs1, rs2, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, func3, rs1, rs2, kill,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_iter_dp.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring
// shift-subtract divide step on the {hi, lo} register pair.
module mdu_iter_dp #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        shifted = {hi, lo[XLEN-1]};
        // Partial remainder stays below 2*b, so diff's MSB is a clean borrow flag.
        diff    = shifted - {1'b0, b};
        hi_nxt  = '0;
        lo_nxt  = '0;
        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, operand/sign
// registers and result register around a one-bit-per-cycle datapath.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_seq_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [2:0]        op;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   bq;
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  cnt;
    logic              neg;
    logic              busy_q;
    logic              done_q;

    logic [XLEN-1:0]   hi_nxt;
    logic [XLEN-1:0]   lo_nxt;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_nxt;
    logic              div_zero;
    logic              ovf;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   fix_val;

    mdu_iter_dp #(.XLEN(XLEN)) u_dp (
        .is_div (is_div(op)),
        .hi     (hi),
        .lo     (lo),
        .b      (bq),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // In PREP, lo holds raw rs1 and bq holds raw rs2.
    always_comb begin
        a_neg    = rs1_signed(op) & lo[XLEN-1];
        b_neg    = rs2_signed(op) & bq[XLEN-1];
        mag_a    = a_neg ? -lo : lo;
        mag_b    = b_neg ? -bq : bq;
        neg_nxt  = is_rem(op) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div(op) && (bq == '0);
        ovf      = ((op == F3_DIV) || (op == F3_REM)) && (lo == MIN_NEG) && (bq == '1);
        if (div_zero) begin
            special_res = op[1] ? lo : '1;
        end else begin
            special_res = op[1] ? '0 : lo;
        end
    end

    always_comb begin
        prod_neg = -{hi, lo};
        case (op)
            F3_MUL:                       fix_val = lo;
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = neg ? prod_neg[2*XLEN-1:XLEN] : hi;
            F3_DIV, F3_DIVU:              fix_val = neg ? -lo : lo;
            default:                      fix_val = neg ? -hi : hi;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op       <= '0;
            hi       <= '0;
            lo       <= '0;
            bq       <= '0;
            result_q <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != S_IDLE && bus.kill) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            op     <= bus.func3;
                            lo     <= bus.rs1;
                            bq     <= bus.rs2;
                            hi     <= '0;
                            state  <= S_PREP;
                            busy_q <= 1'b1;
                        end
                    end
                    S_PREP: begin
                        cnt <= CNT_W'(XLEN - 1);
                        neg <= neg_nxt;
                        hi  <= '0;
                        if (div_zero || ovf) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            // Multiply runs the multiplier through lo; divide shifts the dividend out of lo.
                            lo    <= is_div(op) ? mag_a : mag_b;
                            bq    <= is_div(op) ? mag_b : mag_a;
                            state <= S_ITER;
                        end
                    end
                    S_ITER: begin
                        hi <= hi_nxt;
                        lo <= lo_nxt;
                        if (cnt == '0) begin
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_FIX: begin
                        result_q <= fix_val;
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed RV32M cases, kill/restart/reset
// scenarios and randomized ops against an arithmetic reference model.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mdu_seq_if #(.XLEN(32)) bus ();

    mdu_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] last_exp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f3)
            F3_MUL:    return a * b;
            F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            F3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            F3_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
            F3_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default:   return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 2;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // kill_at / repulse_at: cycle (after acceptance) in which kill / a stray start is driven; 0 = never.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit kill_acc, input int unsigned kill_at, input int unsigned repulse_at);
        logic [31:0] exp;
        int unsigned lat;
        bit          killed;
        exp = ref_mdu(f3, a, b);
        lat = exp_lat(f3, a, b);
        killed = (kill_at != 0) && (kill_at < lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = f3;
        bus.rs1   = a;
        bus.rs2   = b;
        bus.kill  = kill_acc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.func3 = 3'($urandom);
        bus.rs1   = $urandom;
        bus.rs2   = $urandom;
        for (int unsigned c = 1; c <= lat + 1; c++) begin
            bit gone;
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            bus.start = (repulse_at != 0) && (c == repulse_at);
            bus.kill  = (kill_at != 0) && (c == kill_at);
            gone = killed && (c > kill_at);
            chk($sformatf("%s busy c%0d", tag, c), {31'b0, bus.busy}, {31'b0, !gone && c <= lat});
            chk($sformatf("%s done c%0d", tag, c), {31'b0, bus.done}, {31'b0, !gone && c == lat});
            if (c >= lat)
                chk($sformatf("%s result c%0d", tag, c), bus.result, killed ? last_exp : exp);
        end
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        if (!killed) last_exp = exp;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned sel;

        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.func3 = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",   {31'b0, bus.busy}, 32'd0);
        chk("reset done",   {31'b0, bus.done}, 32'd0);
        chk("reset result", bus.result,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("MUL 7*-3",      F3_MUL,    32'd7,          32'hFFFF_FFFD, 1'b0, 0, 0);
        run_op("MULH min*min",  F3_MULH,   32'h8000_0000,  32'h8000_0000, 1'b0, 0, 0);
        run_op("MULHSU -1*2",   F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         1'b0, 0, 0);
        run_op("MULHU max*max", F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 0, 0);
        run_op("DIV -7/2",      F3_DIV,    32'hFFFF_FFF9,  32'd2,         1'b0, 0, 0);
        run_op("REM -7/2",      F3_REM,    32'hFFFF_FFF9,  32'd2,         1'b0, 0, 0);
        run_op("DIVU 100/7",    F3_DIVU,   32'd100,        32'd7,         1'b0, 0, 0);
        run_op("REMU 100/7",    F3_REMU,   32'd100,        32'd7,         1'b0, 0, 0);
        run_op("DIV 5/0",       F3_DIV,    32'd5,          32'd0,         1'b0, 0, 0);
        run_op("REMU 5/0",      F3_REMU,   32'd5,          32'd0,         1'b0, 0, 0);
        run_op("DIV ovf",       F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 0, 0);
        run_op("REM ovf",       F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 0, 0);

        run_op("kill ITER10",   F3_DIVU,   32'd1000,       32'd3,         1'b0, 11, 0);
        run_op("kill FIX",      F3_MUL,    32'd9,          32'd9,         1'b0, 34, 0);
        run_op("kill PREP sp",  F3_DIV,    32'd1,          32'd0,         1'b0, 1,  0);
        run_op("kill DONE",     F3_DIV,    32'hFFFF_FFF9,  32'd2,         1'b0, 35, 0);
        run_op("kill IDLE",     F3_REMU,   32'd55,         32'd10,        1'b1, 0,  0);
        run_op("start repulse", F3_MULHU,  32'hDEAD_BEEF,  32'h1234_5678, 1'b0, 0,  5);

        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = F3_MULH;
        bus.rs1   = 32'h1357_9BDF;
        bus.rs2   = 32'h8642_0ECA;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset busy",   {31'b0, bus.busy}, 32'd0);
        chk("midreset done",   {31'b0, bus.done}, 32'd0);
        chk("midreset result", bus.result,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = 32'd0;
        run_op("MUL 3*4 post-reset", F3_MUL, 32'd3, 32'd4, 1'b0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b, ($urandom_range(0, 3) == 0), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
